// File: rtl/ifu_ctl_pkg.sv
// ifu_ctl_pkg: shared types and constants for the hxd32 fetch sequencer.
//   ifu_state_e    : fetch FSM states (also exported on the debug port)
//   PC_SEL_*       : pc_wr_sel_o encodings
//   PC_INC_*       : pc_inc_sel_o encodings
//   CNT_W          : width of the boot / wait counters (limits up to 255)
//   is_compressed  : RVC detection from the two low instruction bits
package ifu_ctl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } ifu_state_e;

  localparam logic PC_SEL_NEXT = 1'b0;
  localparam logic PC_SEL_ALU  = 1'b1;
  localparam logic PC_INC_4    = 1'b0;
  localparam logic PC_INC_2    = 1'b1;

  localparam int CNT_W = 8;

  // A 32-bit instruction always has 2'b11 in its low bits; anything else
  // is a 16-bit compressed encoding.
  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/ifu_wdt.sv
// ifu_wdt: saturating up-counter with synchronous clear and count enable.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : clear count to zero (has priority over i_en)
//   i_en         : count this cycle
//   o_hit        : high on the enabled cycle that is the LIMIT-th since clear,
//                  so a consumer acting on o_hit reacts after exactly LIMIT
//                  enabled cycles
module ifu_wdt #(
  parameter int W     = 8,
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = i_en && (r_cnt == (LIM - 1'b1));

endmodule

// File: rtl/ifu_ctl.sv
// ifu_ctl: fetch sequencer for the hxd32 IFU.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   iram_rd_req_o       : IRAM read request (address = current PC)
//   iram_rd_gnt_i       : IRAM accepted the request this cycle
//   iram_rd_vld_i       : IRAM read data valid
//   iram_rd_data_i      : IRAM read data
//   inst_vld_o          : instruction held for decode
//   inst_data_o         : held instruction word
//   inst_rdy_i          : decode takes the instruction this cycle
//   br_taken_i          : execute redirect (target on the ALU path)
//   pc_wr_en_o          : PC update strobe (combinational)
//   pc_wr_sel_o         : 0 = sequential PC, 1 = ALU target
//   pc_inc_sel_o        : 0 = +4, 1 = +2
//   fetch_fault_o       : sticky IRAM timeout flag
//   dbg_state_o         : current FSM state
//
// Handshakes: a transfer happens on a cycle where the source's valid/request
// and the sink's ready/grant are both high. Once raised, inst_vld_o and
// inst_data_o stay unchanged until decode accepts or a redirect drops them.
// IRAM read data is accepted only in WAIT; a valid seen in any other state is
// a stale response and is ignored.
module ifu_ctl
  import ifu_ctl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int BOOT_DELAY = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            iram_rd_req_o,
  input  logic            iram_rd_gnt_i,
  input  logic            iram_rd_vld_i,
  input  logic [ILEN-1:0] iram_rd_data_i,
  output logic            inst_vld_o,
  output logic [ILEN-1:0] inst_data_o,
  input  logic            inst_rdy_i,
  input  logic            br_taken_i,
  output logic            pc_wr_en_o,
  output logic            pc_wr_sel_o,
  output logic            pc_inc_sel_o,
  output logic            fetch_fault_o,
  output ifu_state_e      dbg_state_o
);

  if (XLEN < 2 || ILEN < 2 || BOOT_DELAY < 1 || BOOT_DELAY > 255 ||
      MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
    $error("ifu_ctl: parameter out of range");
  end

  ifu_state_e      r_state;
  logic            r_kill;
  logic            r_inst_vld;
  logic [ILEN-1:0] r_inst_data;
  logic            r_fault;

  logic w_active;
  logic w_redirect;
  logic w_accept;
  logic w_gnt_take;
  logic w_boot_done;
  logic w_timeout;

  assign w_active   = (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                      (r_state == ST_HOLD);
  assign w_redirect = w_active && br_taken_i;
  // A redirect beats a same-cycle decode accept.
  assign w_accept   = (r_state == ST_HOLD) && inst_rdy_i && !br_taken_i;
  // A grant during a redirect cycle is not taken: the request is masked.
  assign w_gnt_take = (r_state == ST_REQ) && iram_rd_gnt_i && !br_taken_i;

  ifu_wdt #(.W(CNT_W), .LIMIT(BOOT_DELAY)) u_boot_wdt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (1'b0),
    .i_en  (r_state == ST_BOOT),
    .o_hit (w_boot_done)
  );

  // Counts every WAIT cycle without data, including while a killed response
  // is still outstanding.
  ifu_wdt #(.W(CNT_W), .LIMIT(MAX_WAIT)) u_wait_wdt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (w_gnt_take),
    .i_en  ((r_state == ST_WAIT) && !iram_rd_vld_i),
    .o_hit (w_timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_BOOT;
      r_kill      <= 1'b0;
      r_inst_vld  <= 1'b0;
      r_inst_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (w_boot_done) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (w_gnt_take) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iram_rd_vld_i) begin
            r_kill <= 1'b0;
            if (!r_kill && !br_taken_i) begin
              r_inst_data <= iram_rd_data_i;
              r_inst_vld  <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_state <= ST_REQ;
            end
          end else if (w_timeout) begin
            r_kill  <= 1'b0;
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end else if (br_taken_i) begin
            r_kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (br_taken_i || inst_rdy_i) begin
            r_inst_vld <= 1'b0;
            r_state    <= ST_REQ;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign iram_rd_req_o = (r_state == ST_REQ) && !br_taken_i;
  assign inst_vld_o    = r_inst_vld;
  assign inst_data_o   = r_inst_data;
  assign fetch_fault_o = r_fault;
  assign pc_wr_en_o    = w_redirect || w_accept;
  assign pc_wr_sel_o   = w_redirect ? PC_SEL_ALU : PC_SEL_NEXT;
  assign pc_inc_sel_o  = (w_accept && is_compressed(r_inst_data[1:0])) ?
                         PC_INC_2 : PC_INC_4;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_ifu_ctl.sv
// Bench for ifu_ctl: directed boot/compressed/redirect/timeout/reset
// sequences with hand-computed expectations, followed by randomized traffic,
// all compared every cycle against a behavioural fetch model.
module tb_ifu_ctl;
  import ifu_ctl_pkg::*;

  localparam int BOOT_DELAY = 4;
  localparam int MAX_WAIT   = 15;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic        br  = 1'b0;
  logic [31:0] rdata = '0;

  logic        req;
  logic        ivld;
  logic [31:0] idata;
  logic        wr_en;
  logic        wr_sel;
  logic        inc_sel;
  logic        fault;
  ifu_state_e  dbg_state;

  always #5 clk = ~clk;

  ifu_ctl #(
    .XLEN(32), .ILEN(32), .BOOT_DELAY(BOOT_DELAY), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .iram_rd_req_o  (req),
    .iram_rd_gnt_i  (gnt),
    .iram_rd_vld_i  (vld),
    .iram_rd_data_i (rdata),
    .inst_vld_o     (ivld),
    .inst_data_o    (idata),
    .inst_rdy_i     (rdy),
    .br_taken_i     (br),
    .pc_wr_en_o     (wr_en),
    .pc_wr_sel_o    (wr_sel),
    .pc_inc_sel_o   (inc_sel),
    .fetch_fault_o  (fault),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // boot cycles left, a granted fetch awaiting data, how long it has waited,
  // whether its data must be thrown away, and the instruction held for decode.
  int          m_boot_left = BOOT_DELAY;
  bit          m_fault     = 1'b0;
  bit          m_out       = 1'b0;
  bit          m_discard   = 1'b0;
  int          m_waited    = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot_left = BOOT_DELAY;
      m_fault     = 1'b0;
      m_out       = 1'b0;
      m_discard   = 1'b0;
      m_waited    = 0;
      exp_q.delete();
    end else if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (m_out) begin
      if (vld) begin
        m_out = 1'b0;
        if (!m_discard && !br) exp_q.push_back(rdata);
        m_discard = 1'b0;
      end else if (m_waited + 1 == MAX_WAIT) begin
        m_fault   = 1'b1;
        m_out     = 1'b0;
        m_discard = 1'b0;
      end else begin
        m_waited = m_waited + 1;
        if (br) m_discard = 1'b1;
      end
    end else if (exp_q.size() > 0) begin
      if (br || rdy) exp_q.delete();
    end else if (gnt && !br) begin
      m_out    = 1'b1;
      m_waited = 0;
    end
  end

  // ---------------- compare helpers ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          active;
    bit          holding;
    bit          requesting;
    logic [31:0] hd;
    active     = (m_boot_left == 0) && !m_fault;
    holding    = active && !m_out && (exp_q.size() > 0);
    requesting = active && !m_out && (exp_q.size() == 0);
    hd         = holding ? exp_q[0] : 32'h0;
    chk("req", {31'b0, req}, {31'b0, requesting && !br});
    chk("inst_vld", {31'b0, ivld}, {31'b0, holding});
    if (holding) chk("inst_data", idata, hd);
    chk("pc_wr_en", {31'b0, wr_en}, {31'b0, (active && br) || (holding && rdy)});
    chk("pc_wr_sel", {31'b0, wr_sel}, {31'b0, active && br});
    chk("pc_inc_sel", {31'b0, inc_sel},
        {31'b0, holding && rdy && !br && (hd[1:0] != 2'b11)});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   {31'b0, req},     32'h0);
    chk({tag, "_ivld"},  {31'b0, ivld},    32'h0);
    chk({tag, "_idata"}, idata,            32'h0);
    chk({tag, "_wren"},  {31'b0, wr_en},   32'h0);
    chk({tag, "_sel"},   {31'b0, wr_sel},  32'h0);
    chk({tag, "_inc"},   {31'b0, inc_sel}, 32'h0);
    chk({tag, "_fault"}, {31'b0, fault},   32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit g, input bit v,
                      input logic [31:0] d, input bit y, input bit b);
    @(negedge clk);
    rst = r; gnt = g; vld = v; rdata = d; rdy = y; br = b;
    #1;
    model_check();
  endtask

  // Releases reset and walks cycles 1..5 with grant tied high.
  task automatic boot_seq();
    for (int c = 1; c <= BOOT_DELAY; c++) begin
      step(0, 1, 0, 32'h0, 0, 0);
      chk("boot_req_low", {31'b0, req}, 32'h0);
    end
    step(0, 1, 0, 32'h0, 0, 0);
    chk("first_req_cycle5", {31'b0, req}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  int          vp, gp, bp, yp;
  bit          r_b, g_b, v_b, y_b, b_b;
  logic [31:0] d_r;

  initial begin
    // reset held with every input busy
    step(1, 1, 1, 32'hFFFF_FFFF, 1, 1);
    check_all_zero("in_reset");
    step(1, 1, 1, 32'hFFFF_FFFF, 1, 1);

    // boot timing and plain fetch
    boot_seq();                                   // c1..c5
    step(0, 1, 1, 32'h0000_0013, 0, 0);           // c6 WAIT, data
    chk("c6_ivld_low", {31'b0, ivld}, 32'h0);
    step(0, 1, 0, 32'h0, 1, 0);                   // c7 HOLD, accept
    chk("c7_ivld", {31'b0, ivld}, 32'h1);
    chk("c7_data", idata, 32'h0000_0013);
    chk("c7_wr_en", {31'b0, wr_en}, 32'h1);
    chk("c7_sel", {31'b0, wr_sel}, 32'h0);
    chk("c7_inc", {31'b0, inc_sel}, 32'h0);
    step(0, 1, 0, 32'h0, 0, 0);                   // c8 REQ
    chk("c8_ivld_drop", {31'b0, ivld}, 32'h0);
    chk("c8_req", {31'b0, req}, 32'h1);

    // compressed then full-width
    step(0, 1, 1, 32'h0000_4501, 0, 0);
    step(0, 1, 0, 32'h0, 1, 0);
    chk("rvc_inc", {31'b0, inc_sel}, 32'h1);
    chk("rvc_wr_en", {31'b0, wr_en}, 32'h1);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'h00A0_0093, 0, 0);
    step(0, 1, 0, 32'h0, 1, 0);
    chk("full_inc", {31'b0, inc_sel}, 32'h0);
    chk("full_wr_en", {31'b0, wr_en}, 32'h1);

    // redirect in WAIT
    step(0, 1, 0, 32'h0, 0, 0);                   // REQ, grant
    step(0, 0, 0, 32'h0, 0, 1);                   // WAIT, branch
    chk("wait_br_wr_en", {31'b0, wr_en}, 32'h1);
    chk("wait_br_sel", {31'b0, wr_sel}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0);           // killed response
    step(0, 1, 0, 32'h0, 0, 0);
    chk("after_kill_req", {31'b0, req}, 32'h1);
    chk("after_kill_ivld", {31'b0, ivld}, 32'h0);

    // redirect in HOLD together with ready
    step(0, 0, 1, 32'h0000_0013, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0, 0);
      chk("hold_ivld", {31'b0, ivld}, 32'h1);
    end
    step(0, 0, 0, 32'h0, 1, 1);
    chk("hold_br_wr_en", {31'b0, wr_en}, 32'h1);
    chk("hold_br_sel", {31'b0, wr_sel}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 0);
    chk("hold_br_drop", {31'b0, ivld}, 32'h0);
    chk("hold_br_req", {31'b0, req}, 32'h1);

    // timeout
    step(0, 1, 0, 32'h0, 0, 0);                   // grant
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(0, 0, 0, 32'h0, 0, 0);
      chk("pre_timeout_fault", {31'b0, fault}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 32'h0, 1, 1);
      chk("fault_sticky", {31'b0, fault}, 32'h1);
      chk("fault_no_req", {31'b0, req}, 32'h0);
      chk("fault_no_wr", {31'b0, wr_en}, 32'h0);
    end
    step(1, 0, 0, 32'h0, 0, 0);
    check_all_zero("fault_rst");
    step(1, 0, 0, 32'h0, 0, 0);

    // reset mid-fetch, then a stale response
    boot_seq();                                   // c5 grant -> WAIT
    step(0, 0, 0, 32'h0, 0, 0);                   // c6 WAIT
    step(1, 1, 1, 32'hBAD0_0013, 1, 1);
    check_all_zero("midfetch_rst");
    for (int i = 0; i < BOOT_DELAY; i++) begin
      step(0, 0, 1, 32'hBAD0_0013, 0, 0);
      chk("stale_ivld", {31'b0, ivld}, 32'h0);
      chk("stale_req", {31'b0, req}, 32'h0);
    end
    step(0, 0, 0, 32'h0, 0, 0);
    chk("restart_req", {31'b0, req}, 32'h1);

    // randomized traffic
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0:       vp = 0;
        1:       vp = 10;
        2:       vp = 50;
        default: vp = 90;
      endcase
      gp = $urandom_range(20, 100);
      bp = $urandom_range(0, 15);
      yp = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        r_b = (m_fault && ($urandom_range(0, 19) == 0)) ||
              ($urandom_range(0, 399) == 0);
        g_b = ($urandom_range(1, 100) <= gp);
        v_b = ($urandom_range(1, 100) <= vp);
        y_b = ($urandom_range(1, 100) <= yp);
        b_b = ($urandom_range(1, 100) <= bp);
        d_r = $urandom();
        if ($urandom_range(0, 1) == 1) d_r[1:0] = 2'b11;
        step(r_b, g_b, v_b, d_r, y_b, b_b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
